// File: rtl/mic_adc_sampler.sv
// Periodic serial-ADC reader: a rate-driven tick launches one cs_n/sclk/miso frame,
// and the captured word is presented on mic_signal with a one-cycle wr strobe.
module mic_adc_sampler #(
    parameter int unsigned D_WIDTH    = 8,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned R_WIDTH    = 16,
    parameter int unsigned SIGNED_OUT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [R_WIDTH-1:0] rate,
    input  logic               adc_miso,
    output logic               adc_cs_n,
    output logic               adc_sclk,
    output logic [D_WIDTH-1:0] mic_signal,
    output logic               wr,
    output logic               overrun
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
    localparam logic [D_WIDTH-1:0] MSB_MASK =
        (SIGNED_OUT != 0) ? {1'b1, {(D_WIDTH-1){1'b0}}} : '0;

    typedef enum logic [1:0] {IDLE, START, SHIFT, DONE} state_t;

    state_t             state, state_d;
    logic [R_WIDTH-1:0] cnt, cnt_d, rate_eff;
    logic               tick;
    logic [DIV_W-1:0]   div_cnt, div_d;
    logic [BIT_W-1:0]   bit_cnt, bit_d;
    logic [D_WIDTH-1:0] shreg, sh_d, mic_d;
    logic               cs_d, sclk_d, wr_d, ovr_d;

    // Sample-period counter; a rate shrunk below the current count forces an immediate tick.
    always_comb begin
        rate_eff = (rate < R_WIDTH'(2)) ? R_WIDTH'(2) : rate;
        tick     = en && (cnt >= rate_eff - R_WIDTH'(1));
        cnt_d    = cnt;
        if (en) begin
            cnt_d = tick ? '0 : cnt + R_WIDTH'(1);
        end
    end

    // Frame sequencer: next state and next values of every registered output.
    always_comb begin
        state_d = state;
        div_d   = div_cnt;
        bit_d   = bit_cnt;
        sh_d    = shreg;
        cs_d    = adc_cs_n;
        sclk_d  = adc_sclk;
        mic_d   = mic_signal;
        wr_d    = 1'b0;
        ovr_d   = overrun | (tick && (state != IDLE));
        case (state)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                if (tick) begin
                    state_d = START;
                    cs_d    = 1'b0;
                    div_d   = '0;
                end
            end
            START: begin
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b1;
                    sh_d    = {shreg[D_WIDTH-2:0], adc_miso};
                end else begin
                    div_d = div_cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_cnt != DIV_W'(CLK_DIV - 1)) begin
                    div_d = div_cnt + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (adc_sclk) begin
                        sclk_d = 1'b0;
                    end else if (bit_cnt == BIT_W'(D_WIDTH - 1)) begin
                        // End of the last low phase: close the frame and publish.
                        state_d = DONE;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        mic_d   = shreg ^ MSB_MASK;
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_cnt + BIT_W'(1);
                        sh_d   = {shreg[D_WIDTH-2:0], adc_miso};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b0;
            mic_signal <= '0;
            wr         <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            div_cnt    <= div_d;
            bit_cnt    <= bit_d;
            shreg      <= sh_d;
            adc_cs_n   <= cs_d;
            adc_sclk   <= sclk_d;
            mic_signal <= mic_d;
            wr         <= wr_d;
            overrun    <= ovr_d;
        end
    end

endmodule

// File: tb/tb_mic_adc_sampler.sv
// Directed bench for mic_adc_sampler: a behavioural serial ADC feeds a signed-output
// instance and a raw-output instance that share every input.
module tb_mic_adc_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] rate;
    logic        adc_miso;
    logic        adc_cs_n, adc_sclk, wr, overrun;
    logic [7:0]  mic_signal;
    logic        cs_raw, sclk_raw, wr_raw, ovr_raw;
    logic [7:0]  mic_raw;

    logic [7:0]  adc_word = 8'h00;
    int          pulses = 0;
    int          last_pulses = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mic_adc_sampler dut (
        .clk(clk), .rst(rst), .en(en), .rate(rate), .adc_miso(adc_miso),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .mic_signal(mic_signal),
        .wr(wr), .overrun(overrun)
    );

    mic_adc_sampler #(.SIGNED_OUT(0)) u_raw (
        .clk(clk), .rst(rst), .en(en), .rate(rate), .adc_miso(adc_miso),
        .adc_cs_n(cs_raw), .adc_sclk(sclk_raw), .mic_signal(mic_raw),
        .wr(wr_raw), .overrun(ovr_raw)
    );

    // ADC model: MSB valid once cs_n falls, next bit presented after each sclk rise.
    always @(negedge adc_cs_n or posedge adc_sclk) begin
        if (adc_sclk) pulses = pulses + 1;
        else          pulses = 0;
    end

    always @(posedge adc_cs_n) last_pulses = pulses;

    always_comb begin
        logic [2:0] idx;
        idx      = 3'(7 - pulses);
        adc_miso = (pulses < 8) ? adc_word[idx] : 1'b0;
    end

    task automatic wait_wr(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wr !== 1'b1 && n < limit);
        if (wr !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL wr_timeout: no wr within %0d cycles", limit);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0; rate = 16'd100;
        repeat (2) @(negedge clk);
        n_cmp++; if (adc_cs_n !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n got %b want 1", adc_cs_n); end
        n_cmp++; if (adc_sclk !== 1'b0) begin n_bad++; $display("FAIL rst_sclk got %b want 0", adc_sclk); end
        n_cmp++; if (mic_signal !== 8'h00) begin n_bad++; $display("FAIL rst_mic got %h want 00", mic_signal); end
        n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL rst_wr got %b want 0", wr); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got %b want 0", overrun); end
    endtask

    task automatic test_defaults;
        int n;
        adc_word = 8'hA5; en = 1'b1; rate = 16'd100;
        rst = 1'b1;
        wait_wr(300, n);
        n_cmp++; if (n !== 134) begin n_bad++; $display("FAIL first_wr_latency got %0d want 134", n); end
        for (int f = 0; f < 3; f++) begin
            if (f > 0) begin
                wait_wr(150, n);
                n_cmp++; if (n !== 100) begin n_bad++; $display("FAIL wr_period frame %0d got %0d want 100", f, n); end
            end
            n_cmp++; if (mic_signal !== 8'h25) begin n_bad++; $display("FAIL def_mic frame %0d got %h want 25", f, mic_signal); end
            n_cmp++; if (mic_raw !== 8'hA5) begin n_bad++; $display("FAIL def_raw frame %0d got %h want a5", f, mic_raw); end
            n_cmp++; if (last_pulses !== 8) begin n_bad++; $display("FAIL sclk_pulses frame %0d got %0d want 8", f, last_pulses); end
        end
        @(negedge clk);
        n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL wr_single got %b want 0", wr); end
    endtask

    task automatic test_signed_out;
        int n;
        adc_word = 8'h80;
        wait_wr(150, n);
        n_cmp++; if (mic_signal !== 8'h00) begin n_bad++; $display("FAIL signed_80 got %h want 00", mic_signal); end
        n_cmp++; if (mic_raw !== 8'h80) begin n_bad++; $display("FAIL raw_80 got %h want 80", mic_raw); end
        adc_word = 8'h7F;
        wait_wr(150, n);
        n_cmp++; if (mic_signal !== 8'hFF) begin n_bad++; $display("FAIL signed_7f got %h want ff", mic_signal); end
        n_cmp++; if (mic_raw !== 8'h7F) begin n_bad++; $display("FAIL raw_7f got %h want 7f", mic_raw); end
    endtask

    task automatic test_rate_limit;
        int n;
        adc_word = 8'hA5;
        rate = 16'd36;
        for (int f = 0; f < 10; f++) begin
            wait_wr(100, n);
            n_cmp++; if (n !== 36) begin n_bad++; $display("FAIL rate36_period frame %0d got %0d want 36", f, n); end
        end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rate36_overrun got %b want 0", overrun); end

        @(negedge clk); rst = 1'b0; rate = 16'd35;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_wr(200, n);
        n_cmp++; if (n !== 69) begin n_bad++; $display("FAIL rate35_first got %0d want 69", n); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rate35_ovr_early got %b want 0", overrun); end
        @(negedge clk);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL rate35_ovr_set got %b want 1", overrun); end
        wait_wr(200, n);
        n_cmp++; if (n !== 69) begin n_bad++; $display("FAIL rate35_gap1 got %0d want 69", n); end
        wait_wr(200, n);
        n_cmp++; if (n !== 70) begin n_bad++; $display("FAIL rate35_gap2 got %0d want 70", n); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL rate35_ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_en_drop;
        int n, k, wr_cnt, falls;
        logic prev_cs;
        @(negedge clk); rst = 1'b0; rate = 16'd100; en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        k = 0;
        while (adc_cs_n !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        n_cmp++; if (adc_cs_n !== 1'b0) begin n_bad++; $display("FAIL en_start_timeout cs_n got %b want 0", adc_cs_n); end
        repeat (5) @(negedge clk);
        en = 1'b0;
        wr_cnt = 0; falls = 0; prev_cs = adc_cs_n;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr === 1'b1) wr_cnt++;
            if (prev_cs === 1'b1 && adc_cs_n === 1'b0) falls++;
            prev_cs = adc_cs_n;
        end
        n_cmp++; if (wr_cnt !== 1) begin n_bad++; $display("FAIL en_drop_wr got %0d want 1", wr_cnt); end
        n_cmp++; if (falls !== 0) begin n_bad++; $display("FAIL en_drop_cs got %0d want 0", falls); end
        n_cmp++; if (mic_signal !== 8'h25) begin n_bad++; $display("FAIL en_drop_mic got %h want 25", mic_signal); end
        en = 1'b1;
        wait_wr(300, n);
        n_cmp++; if (n !== 129) begin n_bad++; $display("FAIL en_resume got %0d want 129", n); end
    endtask

    task automatic test_reset_mid_shift;
        int n, k;
        k = 0;
        while (adc_cs_n !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        while (pulses != 5 && k < 300) begin @(negedge clk); k++; end
        n_cmp++; if (pulses !== 5) begin n_bad++; $display("FAIL mid_reach_bit4 got %0d want 5", pulses); end
        rst = 1'b0;
        #1;
        n_cmp++; if (adc_cs_n !== 1'b1) begin n_bad++; $display("FAIL mid_cs_n got %b want 1", adc_cs_n); end
        n_cmp++; if (adc_sclk !== 1'b0) begin n_bad++; $display("FAIL mid_sclk got %b want 0", adc_sclk); end
        n_cmp++; if (mic_signal !== 8'h00) begin n_bad++; $display("FAIL mid_mic got %h want 00", mic_signal); end
        n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL mid_wr got %b want 0", wr); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL mid_overrun got %b want 0", overrun); end
        repeat (3) @(negedge clk);
        n_cmp++; if (wr !== 1'b0) begin n_bad++; $display("FAIL mid_hold_wr got %b want 0", wr); end
        rst = 1'b1;
        wait_wr(300, n);
        n_cmp++; if (n !== 134) begin n_bad++; $display("FAIL mid_first_wr got %0d want 134", n); end
        n_cmp++; if (mic_signal !== 8'h25) begin n_bad++; $display("FAIL mid_sample got %h want 25", mic_signal); end
        n_cmp++; if (last_pulses !== 8) begin n_bad++; $display("FAIL mid_pulses got %0d want 8", last_pulses); end
    endtask

    initial begin
        test_reset;
        test_defaults;
        test_signed_out;
        test_rate_limit;
        test_en_drop;
        test_reset_mid_shift;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
